synaptic_current_reader: RTL and testbench
==========================================

# synaptic_current_reader

Reader end of the synaptic weight store written by the Hebbian learning block. On a start pulse it latches the current spike vector and scans the N×N Q8.8 weight matrix through a one-cycle-latency read port. For each post-synaptic neuron i it accumulates weights[i][j] over all spiking pre-synaptic neurons j≠i. It streams one saturated Q8.8 synaptic current per neuron to the neuron update stage, then pulses done.

## Interface
- N, default 7: neuron count. Index 6 is the FS neuron; this block treats all indices identically.
- W, default 16: weight and current width, signed Q8.8.
- AW, default $clog2(N) (3): row/column address width.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  scan request; sampled only in IDLE.
- spikes_in  in  N  spike vector; latched on the accepted start.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse at scan completion.
- rd_en  out  1  weight read strobe.
- rd_row  out  AW  post-synaptic index i of the read.
- rd_col  out  AW  pre-synaptic index j of the read.
- rd_data  in  W  signed weights[i][j]; valid the cycle after rd_en.
- cur_valid  out  1  cur_idx/cur_data valid this cycle.
- cur_idx  out  AW  neuron index of the emitted current.
- cur_data  out  W  signed Q8.8 synaptic current.

## Operation
- States:
  - IDLE: start=1 latches spikes_in into spk_q, sets row=col=0, and moves to SCAN.
  - SCAN: issues one read per cycle in row-major order (row 0 col 0..N-1, then row 1, ...). After the read of (N-1,N-1), moves to DRAIN.
  - DRAIN: waits for the final data and emission, pulses done, returns to IDLE.
- All N×N entries are read, including the diagonal and non-spiking columns. The scan length is fixed and does not depend on the data.
- Read pipeline: rd_row/rd_col are registered and delayed one cycle as tags alongside rd_data.
- Accumulator:
  - Signed, W+AW bits (19 for defaults).
  - Cleared when column-0 data arrives.
  - Adds sign-extended rd_data only when spk_q[col]=1 and col≠row. The diagonal is excluded even if the stored value is nonzero.
- On column N-1 data, the final sum is saturated to [-32768, +32767] (0x8000..0x7FFF) and registered to cur_data. cur_idx=row and cur_valid=1 for exactly one cycle.
- Currents are emitted in order 0..N-1, exactly N per scan. This holds even when spk_q=0, in which case every current is 0.
- spikes_in changes during a scan are ignored. start while busy=1 is ignored; it is not queued.
- No backpressure: the consumer must accept cur_valid every time it is asserted.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_row=0, rd_col=0, cur_valid=0, cur_idx=0, cur_data=0. State=IDLE and the accumulator is cleared.
- If start is sampled high at the edge ending cycle T:
  - busy=1 from cycle T+1.
  - rd_en=1 in cycles T+1..T+N·N. Cycle T+1+r·N+c carries (r,c).
  - rd_data for that read is consumed in cycle T+2+r·N+c.
  - cur_valid for row r is asserted in cycle T+2+(r+1)·N.
  - done=1 in cycle T+2+N·N, coincident with the last cur_valid. For N=7 this is cycle T+51.
  - busy falls in cycle T+3+N·N; a start sampled at that edge or later is accepted.
- Throughput: one scan per N·N+3 cycles for back-to-back starts.
- Reset mid-scan:
  - All outputs return to their reset values immediately (asynchronous).
  - No done or further cur_valid is produced for the aborted scan.
  - A new start after reset is served normally.

## Test plan
- Reset: assert reset_n=0 mid-run → all outputs 0 asynchronously. Release and idle 10 cycles → no rd_en, cur_valid, or done.
- Uniform: off-diagonal weights 0x0004, diagonal 0x7FFF, spikes_in=7'h7F, start at T → cur_idx 0..6 each with cur_data=0x0018. cur_valid at T+9, T+16, …, T+51; done at T+51; busy low at T+52.
- Sparse: weights[i][j]=16·i+j, spikes_in=7'b1000001 → row0=0x0006, row3=0x0066, row6=0x0060. Rows 1..5 equal 32·i+6.
- Silent: spikes_in=0 with arbitrary weights → seven cur_valid, all cur_data=0, done at T+51.
- Saturation: row 0 off-diagonal weights 0x7000 and row 1 off-diagonal weights 0x9000, all spiking → row0=0x7FFF, row1=0x8000.
- Control: start pulsed at T+10 during busy → ignored, exactly 7 cur_valid. spikes_in toggled mid-scan → results use the spike vector latched at T. reset_n low at T+20 → no done. A new start then yields correct results.

Source files
------------

// File: rtl/synaptic_current_reader_if.sv
// Bundle between the synaptic current reader and its surroundings.
// The slave modport is the reader; the master modport is the controller, weight store and neuron stage.
interface synaptic_current_reader_if #(
    parameter int N  = 7,
    parameter int W  = 16,
    parameter int AW = $clog2(N)
);
    logic          start;
    logic [N-1:0]  spikes_in;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_row;
    logic [AW-1:0] rd_col;
    logic [W-1:0]  rd_data;
    logic          cur_valid;
    logic [AW-1:0] cur_idx;
    logic [W-1:0]  cur_data;

    modport master (
        output start, spikes_in, rd_data,
        input  busy, done, rd_en, rd_row, rd_col, cur_valid, cur_idx, cur_data
    );

    modport slave (
        input  start, spikes_in, rd_data,
        output busy, done, rd_en, rd_row, rd_col, cur_valid, cur_idx, cur_data
    );
endinterface

// File: rtl/synaptic_current_reader.sv
// Scans the NxN Q8.8 weight matrix row-major and emits one saturated
// synaptic current per post-synaptic neuron, summing only spiking off-diagonal inputs.
module synaptic_current_reader #(
    parameter int N  = 7,
    parameter int W  = 16,
    parameter int AW = $clog2(N)
) (
    input logic clk,
    input logic reset_n,
    synaptic_current_reader_if.slave bus
);
    localparam int AccW = W + AW;
    localparam logic [AW-1:0] LastIdx = AW'(N - 1);
    localparam logic signed [AccW-1:0] SatMax = AccW'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [AccW-1:0] SatMin = ~SatMax;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t                 r_state;
    logic [N-1:0]           r_spk;
    logic [AW-1:0]          r_row;
    logic [AW-1:0]          r_col;
    logic                   r_rd_en;
    logic                   r_tag_vld;
    logic [AW-1:0]          r_tag_row;
    logic [AW-1:0]          r_tag_col;
    logic signed [AccW-1:0] r_acc;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_cur_valid;
    logic [AW-1:0]          r_cur_idx;
    logic [W-1:0]           r_cur_data;

    logic signed [AccW-1:0] w_ext;
    logic signed [AccW-1:0] w_base;
    logic signed [AccW-1:0] w_sum;
    logic                   w_use;
    logic [W-1:0]           w_sat;

    // Tags travel one cycle behind the address so they line up with rd_data.
    always_comb begin
        w_ext  = AccW'($signed(bus.rd_data));
        w_use  = r_spk[r_tag_col] && (r_tag_col != r_tag_row);
        w_base = (r_tag_col == '0) ? '0 : r_acc;
        w_sum  = w_base + (w_use ? w_ext : '0);
        if (w_sum > SatMax) begin
            w_sat = {1'b0, {(W-1){1'b1}}};
        end else if (w_sum < SatMin) begin
            w_sat = {1'b1, {(W-1){1'b0}}};
        end else begin
            w_sat = w_sum[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_spk       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_rd_en     <= 1'b0;
            r_tag_vld   <= 1'b0;
            r_tag_row   <= '0;
            r_tag_col   <= '0;
            r_acc       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cur_valid <= 1'b0;
            r_cur_idx   <= '0;
            r_cur_data  <= '0;
        end else begin
            r_done      <= 1'b0;
            r_cur_valid <= 1'b0;
            r_tag_vld   <= r_rd_en;
            r_tag_row   <= r_row;
            r_tag_col   <= r_col;

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_spk   <= bus.spikes_in;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (r_col == LastIdx) begin
                        r_col <= '0;
                        if (r_row == LastIdx) begin
                            r_row   <= '0;
                            r_rd_en <= 1'b0;
                            r_state <= DRAIN;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                DRAIN: begin
                    // r_done marks the cycle the final current is on the bus.
                    if (r_done) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (r_tag_vld) begin
                r_acc <= w_sum;
                if (r_tag_col == LastIdx) begin
                    r_cur_valid <= 1'b1;
                    r_cur_idx   <= r_tag_row;
                    r_cur_data  <= w_sat;
                    r_done      <= (r_tag_row == LastIdx);
                end
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rd_en     = r_rd_en;
    assign bus.rd_row    = r_row;
    assign bus.rd_col    = r_col;
    assign bus.cur_valid = r_cur_valid;
    assign bus.cur_idx   = r_cur_idx;
    assign bus.cur_data  = r_cur_data;
endmodule

// File: tb/tb_synaptic_current_reader.sv
// Randomised scoreboard bench for synaptic_current_reader: expected currents and
// cycle-accurate control timing come from a plain-arithmetic model of the weight matrix.
module tb_synaptic_current_reader;
    localparam int N  = 7;
    localparam int W  = 16;
    localparam int AW = 3;
    localparam int NN = N * N;

    typedef struct {
        int idx;
        int data;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   scan_t = -1;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] weights [N][N];
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    synaptic_current_reader_if #(.N(N), .W(W), .AW(AW)) bus ();

    synaptic_current_reader #(.N(N), .W(W), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Weight store with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= weights[bus.rd_row][bus.rd_col];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},      int'(bus.busy),      0);
        check({tag, " done"},      int'(bus.done),      0);
        check({tag, " rd_en"},     int'(bus.rd_en),     0);
        check({tag, " rd_row"},    int'(bus.rd_row),    0);
        check({tag, " rd_col"},    int'(bus.rd_col),    0);
        check({tag, " cur_valid"}, int'(bus.cur_valid), 0);
        check({tag, " cur_idx"},   int'(bus.cur_idx),   0);
        check({tag, " cur_data"},  int'(bus.cur_data),  0);
    endtask

    // Reference: current[i] = clamp(sum of weights[i][j] over spiking j != i).
    task automatic push_expected(input logic [N-1:0] spk, input int t);
        int   s;
        exp_t e;
        for (int i = 0; i < N; i++) begin
            s = 0;
            for (int j = 0; j < N; j++) begin
                if (j != i && spk[j]) s += int'($signed(weights[i][j]));
            end
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            e.idx  = i;
            e.data = s & 32'hFFFF;
            e.cyc  = t + 2 + (i + 1) * N;
            exp_q.push_back(e);
        end
    endtask

    // Returns at the negedge one cycle after start was presented.
    task automatic issue_start(input logic [N-1:0] spk);
        int g;
        g = 0;
        @(negedge clk);
        while (bus.busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("start_wait_timeout", int'(g < 200), 1);
        bus.start     = 1'b1;
        bus.spikes_in = spk;
        scan_t        = cyc;
        push_expected(spk, cyc);
        $display("start spikes=%b at cycle %0d", spk, cyc);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while ((bus.busy || exp_q.size() != 0) && g < 400);
        check("wait_idle_timeout", int'(g < 400), 1);
    endtask

    task automatic randomize_weights();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                weights[i][j] = W'($urandom);
    endtask

    // Busy start at T+10 and spike noise throughout; optional reset at T+20.
    task automatic control_scan(input logic [N-1:0] spk, input bit do_reset);
        issue_start(spk);
        while (cyc < scan_t + 20) begin
            bus.start     = (cyc == scan_t + 10);
            bus.spikes_in = N'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (do_reset) begin
            #2 reset_n = 1'b0;
            exp_q.delete();
            scan_t = -1;
            #1 check_reset_outputs("mid_scan_reset");
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            repeat (10) @(negedge clk);
        end else begin
            wait_idle();
        end
    endtask

    // Monitor: control timing derived from the start cycle, currents from the queue.
    int   m_rel;
    int   m_ctrl_exp;
    exp_t m_e;
    always @(negedge clk) begin
        if (reset_n) begin
            m_rel = (scan_t >= 0) ? cyc - scan_t : -1;
            m_ctrl_exp = {29'd0, (m_rel >= 1 && m_rel <= NN + 2),
                                 (m_rel >= 1 && m_rel <= NN),
                                 (m_rel == NN + 2)};
            check("ctrl busy/rd_en/done", int'({bus.busy, bus.rd_en, bus.done}), m_ctrl_exp);
            if (m_rel >= 1 && m_rel <= NN) begin
                check("rd_row", int'(bus.rd_row), (m_rel - 1) / N);
                check("rd_col", int'(bus.rd_col), (m_rel - 1) % N);
            end
            if (bus.cur_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cur_unexpected: got idx %0d data 0x%0h required none at cycle %0d",
                             bus.cur_idx, bus.cur_data, cyc);
                end else begin
                    m_e = exp_q.pop_front();
                    $display("cur idx=%0d data=0x%04h cycle=%0d", bus.cur_idx, bus.cur_data, cyc);
                    check("cur_idx",   int'(bus.cur_idx),  m_e.idx);
                    check("cur_data",  int'(bus.cur_data), m_e.data);
                    check("cur_cycle", cyc,                m_e.cyc);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                m_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL cur_missing: got no cur_valid required idx %0d data 0x%0h at cycle %0d",
                         m_e.idx, m_e.data, m_e.cyc);
            end
        end
    end

    initial begin
        bus.start     = 1'b0;
        bus.spikes_in = '0;
        reset_n       = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("power_on_reset");
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Uniform: six spiking neighbours of 0x0004 each; diagonal must be ignored.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                weights[i][j] = (i == j) ? 16'h7FFF : 16'h0004;
        issue_start(7'h7F);
        wait_idle();

        // Sparse
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                weights[i][j] = W'(16 * i + j);
        issue_start(7'b1000001);
        wait_idle();

        // Silent
        randomize_weights();
        issue_start('0);
        wait_idle();

        // Saturation in both directions
        randomize_weights();
        for (int j = 1; j < N; j++) weights[0][j] = 16'h7000;
        for (int j = 0; j < N; j++) if (j != 1) weights[1][j] = 16'h9000;
        issue_start(7'h7F);
        wait_idle();

        // Control: ignored busy start, spike noise, then reset mid-scan and recovery
        randomize_weights();
        control_scan(7'b1010110, 1'b0);
        control_scan(7'b0111001, 1'b1);
        issue_start(7'b1101011);
        wait_idle();

        // Random groups of back-to-back scans
        for (int g = 0; g < 4; g++) begin
            randomize_weights();
            for (int k = 0; k < 3; k++) issue_start(N'($urandom));
            wait_idle();
        end

        check("queue_empty_at_end", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
